// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcodes, ALU operation codes, control-sequencer states
// and the control strobe bundle driven by the sequencer.
package cpu_defs;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHL  = 5'b01000;
    localparam logic [4:0] OP_ADDI = 5'b01001;
    localparam logic [4:0] OP_ANDI = 5'b01010;
    localparam logic [4:0] OP_ORI  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01100;
    localparam logic [4:0] OP_DIV  = 5'b01101;
    localparam logic [4:0] OP_BR   = 5'b01110;
    localparam logic [4:0] OP_JR   = 5'b01111;
    localparam logic [4:0] OP_MFHI = 5'b10000;
    localparam logic [4:0] OP_MFLO = 5'b10001;
    localparam logic [4:0] OP_NOP  = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b10011;

    // ALU codes coincide with the opcodes of the matching register-register instructions.
    localparam logic [4:0] ALU_NONE = 5'b00000;
    localparam logic [4:0] ALU_ADD  = OP_ADD;
    localparam logic [4:0] ALU_AND  = OP_AND;
    localparam logic [4:0] ALU_OR   = OP_OR;

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_FETCH0 = 4'd1,
        ST_FETCH1 = 4'd2,
        ST_FETCH2 = 4'd3,
        ST_T3     = 4'd4,
        ST_T4     = 4'd5,
        ST_T5     = 4'd6,
        ST_T6     = 4'd7,
        ST_T7     = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    typedef struct packed {
        logic PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, InPortout;
        logic PCin, incPC, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, ConIn, OutPortin;
        logic Gra, Grb, Grc, Rin, Rout, BAout;
        logic Read, Write;
        logic [4:0] alu;
    } ctrl_t;

    function automatic logic [4:0] norm_op(input logic [4:0] op);
        return (op > OP_HALT) ? OP_NOP : op;
    endfunction

    function automatic state_t final_state(input logic [4:0] op);
        case (op)
            OP_LD, OP_ST:                                   return ST_T7;
            OP_MUL, OP_DIV, OP_BR:                          return ST_T6;
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHL, OP_ADDI, OP_ANDI, OP_ORI:               return ST_T5;
            default:                                        return ST_T3;
        endcase
    endfunction

    function automatic logic [4:0] imm_alu(input logic [4:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Combinational strobe decode: current sequencer state plus normalised opcode
// (and the branch condition in br T6) map to the full control bundle.
module ctrl_decode
    import cpu_defs::*;
(
    input  state_t     state,
    input  logic [4:0] op,
    input  logic       con_ff,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH0: begin ctrl.PCout = 1'b1; ctrl.MARin = 1'b1; ctrl.incPC = 1'b1; end
            ST_FETCH1: begin ctrl.Read = 1'b1; ctrl.MDRin = 1'b1; end
            ST_FETCH2: begin ctrl.MDRout = 1'b1; ctrl.IRin = 1'b1; end
            ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                case (op)
                    OP_LD, OP_LDI, OP_ST: begin
                        case (state)
                            ST_T3: begin ctrl.Grb = 1'b1; ctrl.BAout = 1'b1; ctrl.Yin = 1'b1; end
                            ST_T4: begin ctrl.Cout = 1'b1; ctrl.Zin = 1'b1; ctrl.alu = ALU_ADD; end
                            ST_T5: begin
                                ctrl.Zlowout = 1'b1;
                                if (op == OP_LDI) begin ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
                                else ctrl.MARin = 1'b1;
                            end
                            ST_T6: begin
                                ctrl.MDRin = 1'b1;
                                if (op == OP_ST) begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; end
                                else ctrl.Read = 1'b1;
                            end
                            ST_T7: begin
                                if (op == OP_ST) ctrl.Write = 1'b1;
                                else begin ctrl.MDRout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
                            end
                            default: ;
                        endcase
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        case (state)
                            ST_T3: begin ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Yin = 1'b1; end
                            ST_T4: begin
                                ctrl.Zin = 1'b1;
                                if (op >= OP_ADDI) begin ctrl.Cout = 1'b1; ctrl.alu = imm_alu(op); end
                                else begin ctrl.Grc = 1'b1; ctrl.Rout = 1'b1; ctrl.alu = op; end
                            end
                            ST_T5: begin ctrl.Zlowout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_MUL, OP_DIV: begin
                        case (state)
                            ST_T3: begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.Yin = 1'b1; end
                            ST_T4: begin ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Zin = 1'b1; ctrl.alu = op; end
                            ST_T5: begin ctrl.Zlowout = 1'b1; ctrl.LOin = 1'b1; end
                            ST_T6: begin ctrl.Zhighout = 1'b1; ctrl.HIin = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_BR: begin
                        case (state)
                            ST_T3: begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.ConIn = 1'b1; end
                            ST_T4: begin ctrl.PCout = 1'b1; ctrl.Yin = 1'b1; end
                            ST_T5: begin ctrl.Cout = 1'b1; ctrl.Zin = 1'b1; ctrl.alu = ALU_ADD; end
                            ST_T6: begin ctrl.Zlowout = con_ff; ctrl.PCin = con_ff; end
                            default: ;
                        endcase
                    end
                    OP_JR:   if (state == ST_T3) begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.PCin = 1'b1; end
                    OP_MFHI: if (state == ST_T3) begin ctrl.HIout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
                    OP_MFLO: if (state == ST_T3) begin ctrl.LOout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch, opcode-specific execute, optional halt at
// the instruction boundary. The current state is exported for observation.
module control_unit
    import cpu_defs::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        stop,
    output logic        PCout, Zlowout, Zhighout, MDRout, HIout, LOout, Cout, InPortout,
    output logic        PCin, incPC, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, ConIn, OutPortin,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout,
    output logic        Read, Write,
    output logic [4:0]  aluControl,
    output logic        run,
    output state_t      state
);

    logic [4:0] op;
    logic       unused_ir;
    ctrl_t      ctrl;

    assign op        = norm_op(ir[31:27]);
    assign unused_ir = ^ir[26:0];

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= ST_RESET;
        end else begin
            case (state)
                ST_RESET:  state <= ST_FETCH0;
                ST_FETCH0: state <= ST_FETCH1;
                ST_FETCH1: state <= ST_FETCH2;
                ST_FETCH2: state <= ST_T3;
                ST_HALT:   state <= ST_HALT;
                default: begin
                    if (op == OP_HALT)
                        state <= ST_HALT;
                    else if (state == final_state(op))
                        state <= stop ? ST_HALT : ST_FETCH0;
                    else
                        state <= state_t'(state + 4'd1);
                end
            endcase
        end
    end

    ctrl_decode u_decode (
        .state  (state),
        .op     (op),
        .con_ff (con_ff),
        .ctrl   (ctrl)
    );

    assign run = (state != ST_RESET) && (state != ST_HALT);

    assign PCout      = ctrl.PCout;
    assign Zlowout    = ctrl.Zlowout;
    assign Zhighout   = ctrl.Zhighout;
    assign MDRout     = ctrl.MDRout;
    assign HIout      = ctrl.HIout;
    assign LOout      = ctrl.LOout;
    assign Cout       = ctrl.Cout;
    assign InPortout  = ctrl.InPortout;
    assign PCin       = ctrl.PCin;
    assign incPC      = ctrl.incPC;
    assign MARin      = ctrl.MARin;
    assign MDRin      = ctrl.MDRin;
    assign IRin       = ctrl.IRin;
    assign Yin        = ctrl.Yin;
    assign Zin        = ctrl.Zin;
    assign HIin       = ctrl.HIin;
    assign LOin       = ctrl.LOin;
    assign ConIn      = ctrl.ConIn;
    assign OutPortin  = ctrl.OutPortin;
    assign Gra        = ctrl.Gra;
    assign Grb        = ctrl.Grb;
    assign Grc        = ctrl.Grc;
    assign Rin        = ctrl.Rin;
    assign Rout       = ctrl.Rout;
    assign BAout      = ctrl.BAout;
    assign Read       = ctrl.Read;
    assign Write      = ctrl.Write;
    assign aluControl = ctrl.alu;

endmodule
